vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_axis_counter.sv | 41 ++++
 rtl/vga_timing_gen.sv | 168 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing presets, colour-triple layout and width helper for the VGA generator
package vga_pkg;

    localparam int SVGA72_H_VISIBLE = 800;
    localparam int SVGA72_H_FP      = 56;
    localparam int SVGA72_H_SYNC    = 120;
    localparam int SVGA72_H_BP      = 64;
    localparam int SVGA72_V_VISIBLE = 600;
    localparam int SVGA72_V_FP      = 37;
    localparam int SVGA72_V_SYNC    = 6;
    localparam int SVGA72_V_BP      = 23;

    localparam int VGA60_H_VISIBLE  = 640;
    localparam int VGA60_H_FP       = 16;
    localparam int VGA60_H_SYNC     = 96;
    localparam int VGA60_H_BP       = 48;
    localparam int VGA60_V_VISIBLE  = 480;
    localparam int VGA60_V_FP       = 10;
    localparam int VGA60_V_SYNC     = 2;
    localparam int VGA60_V_BP       = 33;

    // Field index inside a {R,G,B} triple, counted from the LSB end in units of COLOR_W.
    localparam int R_FIELD = 2;
    localparam int G_FIELD = 1;
    localparam int B_FIELD = 0;
    localparam int TRIPLE  = 3;

    // Never returns 0 so single-value counters still get a 1-bit register.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: wrapping counter with sync and visible region decode
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VISIBLE = 800,
    parameter int FP      = 56,
    parameter int SYNC    = 120,
    parameter int BP      = 64
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     ce,
    input  logic                                     wrap_in,
    output logic [clog2(VISIBLE+FP+SYNC+BP)-1:0]     count,
    output logic                                     sync_active,
    output logic                                     visible,
    output logic                                     wrap_out
);

    localparam int TOTAL = VISIBLE + FP + SYNC + BP;
    localparam int CW    = clog2(TOTAL);

    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] VIS_END    = CW'(VISIBLE);
    localparam logic [CW-1:0] SYNC_FIRST = CW'(VISIBLE + FP);
    localparam logic [CW-1:0] SYNC_LAST  = CW'(VISIBLE + FP + SYNC - 1);

    // wrap_in chains the axes: the vertical axis only steps when the horizontal one wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (ce && wrap_in) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign wrap_out    = wrap_in && (count == LAST);
    assign visible     = (count < VIS_END);
    assign sync_active = (count >= SYNC_FIRST) && (count <= SYNC_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator with banded, frame-buffered colour code
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = SVGA72_H_VISIBLE,
    parameter int H_FP      = SVGA72_H_FP,
    parameter int H_SYNC    = SVGA72_H_SYNC,
    parameter int H_BP      = SVGA72_H_BP,
    parameter int V_VISIBLE = SVGA72_V_VISIBLE,
    parameter int V_FP      = SVGA72_V_FP,
    parameter int V_SYNC    = SVGA72_V_SYNC,
    parameter int V_BP      = SVGA72_V_BP,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter int COLOR_W   = 4,
    parameter int NUM_COLS  = 2
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               pix_ce,
    input  logic [NUM_COLS*3*COLOR_W-1:0]                      code,
    input  logic                                               code_wr,
    output logic                                               hsync,
    output logic                                               vsync,
    output logic [COLOR_W-1:0]                                 red,
    output logic [COLOR_W-1:0]                                 green,
    output logic [COLOR_W-1:0]                                 blue,
    output logic                                               blank,
    output logic [clog2(H_VISIBLE+H_FP+H_SYNC+H_BP)-1:0]       pix_x,
    output logic [clog2(V_VISIBLE+V_FP+V_SYNC+V_BP)-1:0]       pix_y,
    output logic                                               frame_start,
    output logic                                               line_end
);

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int XW       = clog2(H_TOTAL);
    localparam int YW       = clog2(V_TOTAL);
    localparam int TRIPLE_W = TRIPLE * COLOR_W;
    localparam int CODE_W   = NUM_COLS * TRIPLE_W;
    localparam int BAND_W   = H_VISIBLE / NUM_COLS;
    localparam int BW_W     = clog2(BAND_W);
    localparam int CI_W     = clog2(NUM_COLS);

    localparam logic [BW_W-1:0] BAND_LAST = BW_W'(BAND_W - 1);
    localparam logic [CI_W-1:0] COL_LAST  = CI_W'(NUM_COLS - 1);

    if (H_VISIBLE % NUM_COLS != 0) begin : g_chk_cols
        $error("H_VISIBLE must be a multiple of NUM_COLS");
    end
    if (H_SYNC == 0 || V_SYNC == 0) begin : g_chk_sync
        $error("sync widths must be non-zero");
    end

    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic          h_sync, v_sync, h_vis, v_vis, h_wrap, v_wrap;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FP      (H_FP),
        .SYNC    (H_SYNC),
        .BP      (H_BP)
    ) u_h_axis (
        .clk         (clk),
        .rst         (rst),
        .ce          (pix_ce),
        .wrap_in     (1'b1),
        .count       (h_cnt),
        .sync_active (h_sync),
        .visible     (h_vis),
        .wrap_out    (h_wrap)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FP      (V_FP),
        .SYNC    (V_SYNC),
        .BP      (V_BP)
    ) u_v_axis (
        .clk         (clk),
        .rst         (rst),
        .ce          (pix_ce),
        .wrap_in     (h_wrap),
        .count       (v_cnt),
        .sync_active (v_sync),
        .visible     (v_vis),
        .wrap_out    (v_wrap)
    );

    logic [BW_W-1:0]   col_cnt;
    logic [CI_W-1:0]   col_idx;
    logic [CODE_W-1:0] shadow, active;
    logic              pending;

    // Band index advances every BAND_W visible pixels and parks on the last band through blanking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            col_idx <= '0;
        end else if (pix_ce) begin
            if (h_wrap) begin
                col_cnt <= '0;
                col_idx <= '0;
            end else if (h_vis && col_cnt == BAND_LAST) begin
                col_cnt <= '0;
                if (col_idx != COL_LAST) col_idx <= col_idx + 1'b1;
            end else if (h_vis) begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // The frame-end pixel is always blanked, so swapping there never alters a visible frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (code_wr) shadow <= code;
            if (pix_ce && v_wrap) begin
                if (code_wr) active <= code;
                else if (pending) active <= shadow;
                pending <= 1'b0;
            end else if (code_wr) begin
                pending <= 1'b1;
            end
        end
    end

    logic [TRIPLE_W-1:0] bands [NUM_COLS];
    for (genvar i = 0; i < NUM_COLS; i++) begin : g_band
        assign bands[i] = active[(NUM_COLS-1-i)*TRIPLE_W +: TRIPLE_W];
    end

    logic [TRIPLE_W-1:0] band_sel;
    logic                vis;
    assign band_sel = bands[col_idx];
    assign vis      = h_vis && v_vis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            blank       <= 1'b1;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
        end else if (pix_ce) begin
            hsync       <= h_sync ~^ HSYNC_POL;
            vsync       <= v_sync ~^ VSYNC_POL;
            red         <= vis ? band_sel[R_FIELD*COLOR_W +: COLOR_W] : '0;
            green       <= vis ? band_sel[G_FIELD*COLOR_W +: COLOR_W] : '0;
            blue        <= vis ? band_sel[B_FIELD*COLOR_W +: COLOR_W] : '0;
            blank       <= ~vis;
            pix_x       <= h_cnt;
            pix_y       <= v_cnt;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            line_end    <= h_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen against a coordinate-based reference model
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int HV = 8, HFP = 2, HS = 2, HBP = 2;
    localparam int VV = 4, VFP = 1, VS = 1, VBP = 1;
    localparam bit HPOL = 1'b0;
    localparam bit VPOL = 1'b1;
    localparam int CWD  = 4;
    localparam int NC   = 4;
    localparam int HT   = HV + HFP + HS + HBP;
    localparam int VT   = VV + VFP + VS + VBP;
    localparam int BW   = HV / NC;
    localparam int XW   = clog2(HT);
    localparam int YW   = clog2(VT);
    localparam int CODW = NC * 3 * CWD;
    localparam int OW   = 2 + 3*CWD + 1 + XW + YW + 2;

    localparam logic [OW-1:0] RST_VEC = {~HPOL, ~VPOL, {(3*CWD){1'b0}}, 1'b1, {XW{1'b0}}, {YW{1'b0}}, 2'b00};

    logic            clk, rst, pix_ce, code_wr;
    logic [CODW-1:0] code;
    logic            hsync, vsync, blank, frame_start, line_end;
    logic [CWD-1:0]  red, green, blue;
    logic [XW-1:0]   pix_x;
    logic [YW-1:0]   pix_y;

    vga_timing_gen #(
        .H_VISIBLE (HV), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_VISIBLE (VV), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .HSYNC_POL (HPOL), .VSYNC_POL (VPOL),
        .COLOR_W   (CWD), .NUM_COLS (NC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .code        (code),
        .code_wr     (code_wr),
        .hsync       (hsync),
        .vsync       (vsync),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .blank       (blank),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .line_end    (line_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [OW-1:0]   exp_q [$];
    logic [OW-1:0]   held = RST_VEC;
    bit              ce_q = 1'b0;

    int              mx, my;
    logic [CODW-1:0] act_m, sh_m;
    bit              pend_m;

    function automatic logic [OW-1:0] expect_at(input int x, input int y, input logic [CODW-1:0] act);
        logic [3*CWD-1:0] trip;
        bit vis, hs_lvl, vs_lvl;
        vis    = (x < HV) && (y < VV);
        trip   = vis ? act[(NC-1-x/BW)*3*CWD +: 3*CWD] : '0;
        hs_lvl = (x >= HV+HFP && x < HV+HFP+HS) ? HPOL : !HPOL;
        vs_lvl = (y >= VV+VFP && y < VV+VFP+VS) ? VPOL : !VPOL;
        return {hs_lvl, vs_lvl, trip, !vis, XW'(x), YW'(y), (x == 0 && y == 0), (x == HT-1)};
    endfunction

    task automatic chk(input string name, input logic [OW-1:0] got, input logic [OW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    always @(posedge clk) ce_q <= pix_ce;

    // Monitor: every pix_ce edge presents one new output vector; other edges must hold.
    always @(negedge clk) begin
        logic [OW-1:0] got;
        got = {hsync, vsync, red, green, blue, blank, pix_x, pix_y, frame_start, line_end};
        if (rst) begin
            chk("reset", got, RST_VEC);
            held = RST_VEC;
        end else if (ce_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL underflow at %0t: got output with no expectation, expected queued entry", $time);
            end else begin
                held = exp_q.pop_front();
                chk("pixel", got, held);
            end
        end else begin
            chk("hold", got, held);
        end
    end

    task automatic step(input bit ce, input bit wr, input logic [CODW-1:0] c);
        bit frame_last;
        pix_ce  = ce;
        code_wr = wr;
        code    = c;
        if (ce) exp_q.push_back(expect_at(mx, my, act_m));
        frame_last = ce && (mx == HT-1) && (my == VT-1);
        if (frame_last) begin
            if (wr) act_m = c;
            else if (pend_m) act_m = sh_m;
            pend_m = 1'b0;
        end else if (wr) begin
            pend_m = 1'b1;
        end
        if (wr) sh_m = c;
        if (ce) begin
            mx = (mx + 1) % HT;
            if (mx == 0) my = (my + 1) % VT;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        pix_ce  = 1'b0;
        code_wr = 1'b0;
        rst     = 1'b1;
        mx = 0; my = 0; act_m = '0; sh_m = '0; pend_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [CODW-1:0] rand_code();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[CODW-1:0];
    endfunction

    initial begin
        rst = 1'b1; pix_ce = 1'b0; code_wr = 1'b0; code = '0;
        mx = 0; my = 0; act_m = '0; sh_m = '0; pend_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Band pattern queued before the first frame, visible from the second frame on.
        step(1'b0, 1'b1, 48'hF000F000FFFF);
        repeat (2*HT*VT) step(1'b1, 1'b0, '0);

        // Writes at arbitrary mid-frame points.
        for (int i = 0; i < 3*HT*VT; i++)
            step(1'b1, ($urandom_range(0, 39) == 0), rand_code());

        // Writes landing exactly on the frame-end pixel.
        for (int i = 0; i < 3*HT*VT; i++)
            step(1'b1, (mx == HT-1 && my == VT-1), rand_code());

        // Half-rate pixel enable.
        for (int i = 0; i < 4*HT*VT; i++)
            step((i % 2 == 0), 1'b0, '0);

        // Random enable and write traffic.
        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0), rand_code());

        // Reset in the middle of a line, then restart from the origin.
        for (int i = 0; i < HT*VT && !(mx == 3 && my == 1); i++)
            step(1'b1, 1'b0, '0);
        do_reset();
        step(1'b0, 1'b1, rand_code());
        repeat (2*HT*VT + 5) step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
